ad7606_ctrl: RTL
================

Name: ad7606_ctrl

Overview:
FPGA-side sequencer for one AD7606 8-channel 16-bit simultaneous-sampling ADC in parallel-interface mode. On each trigger it pulses CONVST, waits for BUSY to assert then drop, then performs eight CS/RD read strobes. It emits each captured word on a valid-qualified sample stream tagged with its channel index. It sits between the ADC pins (db, convst, cs, rd, busy, frstdata, reset, os) and the downstream sample FIFO/packetiser.

Parameters:
- NUM_CH, 8: reads per frame, 1..8.
- RST_CYC, 8: cycles adc_reset_o is held high after controller reset release; the ADC needs at least 50 ns.
- CONVST_LO_CYC, 2: convst_o low width in cycles, at least 1.
- RD_LO_CYC, 3: rd_o low width in cycles; must cover the ADC's 16 ns data-valid delay plus 2 cycles.
- RD_HI_CYC, 2: rd_o high width between strobes, at least 1.
- BUSY_TO_CYC, 40000: timeout in cycles for each busy wait; must exceed the maximum conversion time at os=110.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle conversion trigger.
- os_cfg_i  in  3  oversampling select; latched when start_i is accepted.
- os_o  out  3  ADC OS[2:0] pins.
- adc_reset_o  out  1  ADC RESET pin, active high.
- convst_o  out  1  ADC CONVST A/B tied, active-low pulse.
- cs_o  out  1  ADC CS, active low.
- rd_o  out  1  ADC RD, active low.
- busy_i  in  1  ADC BUSY, asynchronous.
- frstdata_i  in  1  ADC FRSTDATA.
- db_i  in  16  ADC data bus.
- ready_o  out  1  high in IDLE; start_i is accepted only when ready_o is high.
- sample_o  out  16  captured sample.
- sample_ch_o  out  3  channel index of sample_o, 0..NUM_CH-1.
- sample_valid_o  out  1  single-cycle strobe qualifying sample_o and sample_ch_o.
- frame_done_o  out  1  single-cycle pulse after the last channel is emitted.
- err_timeout_o  out  1  sticky; cleared by the next accepted start_i.

Behaviour:
- Reset values:
  - convst_o=1, cs_o=1, rd_o=1, adc_reset_o=1, os_o=0.
  - ready_o=0, sample_o=0, sample_ch_o=0, sample_valid_o=0, frame_done_o=0, err_timeout_o=0.
  - FSM in ADC_RST.
- busy_i passes through a 2-flop synchroniser before use. frstdata_i and db_i are sampled directly; they are stable while rd_o is low.
- FSM states:
  - ADC_RST: hold adc_reset_o=1 for RST_CYC cycles, then drive 0 and go to IDLE.
  - IDLE: ready_o=1. On start_i, latch os_cfg_i into os_o, clear err_timeout_o and go to CONV_LO.
  - CONV_LO: convst_o=0 for CONVST_LO_CYC cycles, then convst_o=1 and go to WAIT_BUSY_HI.
  - WAIT_BUSY_HI: wait for synchronised busy=1, then go to WAIT_BUSY_LO.
  - WAIT_BUSY_LO: wait for synchronised busy=0, then cs_o=0, clear the channel counter and go to RD_LO.
  - RD_LO: rd_o=0 for RD_LO_CYC cycles. On the last cycle, register db_i into sample_o; the next cycle pulses sample_valid_o with sample_ch_o equal to the counter. Then go to RD_HI.
  - RD_HI: rd_o=1 for RD_HI_CYC cycles. Increment the counter. If counter==NUM_CH, set cs_o=1, pulse frame_done_o and go to IDLE; otherwise go to RD_LO.
- Timeout:
  - Each busy-wait state runs its own counter. At BUSY_TO_CYC cycles, set err_timeout_o=1 and go to ADC_RST, which re-resets the ADC.
  - No samples and no frame_done_o are emitted for an aborted frame.
- Sequencing rules:
  - start_i is ignored while ready_o=0; starts are not queued.
  - Strobe pattern: cs_o falls with the first rd_o fall; each rd_o edge is registered and glitch-free. cs_o stays low for the whole burst.
  - A busy rise inside the synchroniser delay is still caught, because busy stays high for at least 4 µs.
- Counter and sample-stream arithmetic:
  - The channel counter is 4 bits, so NUM_CH=8 compares without wrap.
  - sample_ch_o carries the 3 LSBs.
  - sample_valid_o and frame_done_o are never high in the same cycle. frame_done_o follows the last sample_valid_o by at least 1 cycle.
- Reset mid-operation: reset_n_i low forces all outputs to their reset values immediately. Any frame in progress is discarded.

Optional Feature:
- Macro: AD7606_FRSTDATA_CHECK_EN.
- Defined:
  - On channel 0's capture, frstdata_i must be 1. On every other channel it must be 0.
  - A mismatch sets a sticky err_frst_o output (1 bit, reset 0, cleared by the next accepted start_i).
  - The frame still completes.
- Undefined: the port err_frst_o is absent, frstdata_i is unused, and the behaviour is otherwise identical.

Decomposition:
- Package ad7606_pkg:
  - FSM state enum: ADC_RST, IDLE, CONV_LO, WAIT_BUSY_HI, WAIT_BUSY_LO, RD_LO, RD_HI.
  - OS encoding constants OS_NONE=3'b000 through OS_X64=3'b110.
  - Width constants DATA_W=16 and CH_W=3.
- One sub-module: sync_2ff, a 1-bit two-flop synchroniser with async active-low reset. It is reused for busy_i.

Test Plan:
- Reset release with RST_CYC=8: adc_reset_o stays high for 8 cycles after reset_n_i rises, then drops; ready_o rises the next cycle.
- start_i with os_cfg_i=000, ADC model with 4 µs busy and db returning 0x1234, 0x0001 … 0x0007: exactly 8 sample_valid_o pulses with ch 0..7 and matching data; then frame_done_o; cs_o low for the entire burst.
- busy_i held 0 after convst with BUSY_TO_CYC=100: err_timeout_o=1 at cycle 100 of WAIT_BUSY_HI; adc_reset_o re-pulses; no sample_valid_o; the next start clears the error.
- start_i pulsed while in RD_LO: ignored; the frame still yields exactly NUM_CH samples; no second conversion occurs.
- reset_n_i asserted during RD_LO of channel 3: cs_o=1 and rd_o=1 immediately; sample_valid_o=0; FSM restarts in ADC_RST.
- AD7606_FRSTDATA_CHECK_EN defined, model drives frstdata high on channel 1 instead of 0: err_frst_o=1 after that capture; frame_done_o still pulses.

Source files
------------

// File: rtl/ad7606_pkg.sv
// Shared types and constants for the AD7606 parallel-mode sequencer.
// Holds the FSM state enum, OS pin encodings and bus widths.
package ad7606_pkg;

  typedef enum logic [2:0] {
    ADC_RST,
    IDLE,
    CONV_LO,
    WAIT_BUSY_HI,
    WAIT_BUSY_LO,
    RD_LO,
    RD_HI
  } state_e;

  localparam logic [2:0] OS_NONE = 3'b000;
  localparam logic [2:0] OS_X2   = 3'b001;
  localparam logic [2:0] OS_X4   = 3'b010;
  localparam logic [2:0] OS_X8   = 3'b011;
  localparam logic [2:0] OS_X16  = 3'b100;
  localparam logic [2:0] OS_X32  = 3'b101;
  localparam logic [2:0] OS_X64  = 3'b110;

  localparam int DATA_W = 16;
  localparam int CH_W   = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ad7606_ctrl_sync.sv
// sync_2ff: 1-bit two-flop synchroniser, async active-low reset to 0.
// Ports: clk_i, rst_ni, d_i (async in), q_o (synchronised out).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ad7606_ctrl.sv
// AD7606 sequencer: CONVST pulse, BUSY wait, NUM_CH CS/RD reads, sample stream.
// Ports: clk_i, reset_n_i, start_i, os_cfg_i | ADC pins os_o, adc_reset_o,
//   convst_o, cs_o, rd_o, busy_i, frstdata_i, db_i | ready_o, sample_o,
//   sample_ch_o, sample_valid_o, frame_done_o, err_timeout_o.
// Option AD7606_FRSTDATA_CHECK_EN adds sticky err_frst_o.
module ad7606_ctrl
  import ad7606_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int RST_CYC       = 8,
  parameter int CONVST_LO_CYC = 2,
  parameter int RD_LO_CYC     = 3,
  parameter int RD_HI_CYC     = 2,
  parameter int BUSY_TO_CYC   = 40000
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [2:0]        os_cfg_i,
  output logic [2:0]        os_o,
  output logic              adc_reset_o,
  output logic              convst_o,
  output logic              cs_o,
  output logic              rd_o,
  input  logic              busy_i,
  input  logic              frstdata_i,
  input  logic [DATA_W-1:0] db_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] sample_o,
  output logic [CH_W-1:0]   sample_ch_o,
  output logic              sample_valid_o,
  output logic              frame_done_o,
  output logic              err_timeout_o
`ifdef AD7606_FRSTDATA_CHECK_EN
  ,
  output logic              err_frst_o
`endif
);

  localparam int CMAX = max2(max2(BUSY_TO_CYC, RST_CYC),
                        max2(CONVST_LO_CYC, max2(RD_LO_CYC, RD_HI_CYC)));
  localparam int TW = $clog2(CMAX + 1);

  state_e state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [3:0] ch_q, ch_d;
  logic [3:0] ch_inc;
  logic busy_s;

  logic convst_q, convst_d;
  logic cs_q, cs_d;
  logic rd_q, rd_d;
  logic adc_rst_q, adc_rst_d;
  logic [2:0] os_q, os_d;
  logic ready_q, ready_d;
  logic [DATA_W-1:0] smp_q, smp_d;
  logic [CH_W-1:0] sch_q, sch_d;
  logic vld_q, vld_d;
  logic done_q, done_d;
  logic to_q, to_d;
  logic frst_q, frst_d;

  sync_2ff u_busy_sync (
    .clk_i  (clk_i),
    .rst_ni (reset_n_i),
    .d_i    (busy_i),
    .q_o    (busy_s)
  );

  assign ch_inc = ch_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + TW'(1);
    ch_d      = ch_q;
    convst_d  = convst_q;
    cs_d      = cs_q;
    rd_d      = rd_q;
    adc_rst_d = adc_rst_q;
    os_d      = os_q;
    smp_d     = smp_q;
    sch_d     = sch_q;
    vld_d     = 1'b0;
    done_d    = 1'b0;
    to_d      = to_q;
    frst_d    = frst_q;

    unique case (state_q)
      ADC_RST: begin
        if (cnt_q == TW'(RST_CYC - 1)) begin
          adc_rst_d = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end
      IDLE: begin
        // ready_q already implies IDLE; it lags entry by one cycle.
        if (ready_q && start_i) begin
          os_d     = os_cfg_i;
          to_d     = 1'b0;
          frst_d   = 1'b0;
          convst_d = 1'b0;
          cnt_d    = '0;
          state_d  = CONV_LO;
        end
      end
      CONV_LO: begin
        if (cnt_q == TW'(CONVST_LO_CYC - 1)) begin
          convst_d = 1'b1;
          cnt_d    = '0;
          state_d  = WAIT_BUSY_HI;
        end
      end
      WAIT_BUSY_HI: begin
        if (busy_s) begin
          cnt_d   = '0;
          state_d = WAIT_BUSY_LO;
        end else if (cnt_q == TW'(BUSY_TO_CYC - 1)) begin
          to_d      = 1'b1;
          adc_rst_d = 1'b1;
          cnt_d     = '0;
          state_d   = ADC_RST;
        end
      end
      WAIT_BUSY_LO: begin
        if (!busy_s) begin
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          ch_d    = '0;
          cnt_d   = '0;
          state_d = RD_LO;
        end else if (cnt_q == TW'(BUSY_TO_CYC - 1)) begin
          to_d      = 1'b1;
          adc_rst_d = 1'b1;
          cnt_d     = '0;
          state_d   = ADC_RST;
        end
      end
      RD_LO: begin
        if (cnt_q == TW'(RD_LO_CYC - 1)) begin
          smp_d   = db_i;
          sch_d   = ch_q[CH_W-1:0];
          vld_d   = 1'b1;
          rd_d    = 1'b1;
          cnt_d   = '0;
          state_d = RD_HI;
`ifdef AD7606_FRSTDATA_CHECK_EN
          if ((ch_q == 4'd0) != frstdata_i) frst_d = 1'b1;
`endif
        end
      end
      RD_HI: begin
        if (cnt_q == TW'(RD_HI_CYC - 1)) begin
          cnt_d = '0;
          ch_d  = ch_inc;
          if (ch_inc == 4'(NUM_CH)) begin
            cs_d    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rd_d    = 1'b0;
            state_d = RD_LO;
          end
        end
      end
      default: begin
        adc_rst_d = 1'b1;
        cnt_d     = '0;
        state_d   = ADC_RST;
      end
    endcase

    ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ADC_RST;
      cnt_q     <= '0;
      ch_q      <= '0;
      convst_q  <= 1'b1;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      adc_rst_q <= 1'b1;
      os_q      <= OS_NONE;
      ready_q   <= 1'b0;
      smp_q     <= '0;
      sch_q     <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      frst_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      convst_q  <= convst_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      adc_rst_q <= adc_rst_d;
      os_q      <= os_d;
      ready_q   <= ready_d;
      smp_q     <= smp_d;
      sch_q     <= sch_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      to_q      <= to_d;
      frst_q    <= frst_d;
    end
  end

  assign os_o           = os_q;
  assign adc_reset_o    = adc_rst_q;
  assign convst_o       = convst_q;
  assign cs_o           = cs_q;
  assign rd_o           = rd_q;
  assign ready_o        = ready_q;
  assign sample_o       = smp_q;
  assign sample_ch_o    = sch_q;
  assign sample_valid_o = vld_q;
  assign frame_done_o   = done_q;
  assign err_timeout_o  = to_q;

`ifdef AD7606_FRSTDATA_CHECK_EN
  assign err_frst_o = frst_q;
`else
  logic unused_frst;
  assign unused_frst = frstdata_i | frst_q;
`endif

endmodule
